// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer_if
//  Description : Bundle of ROM, register-file, ALU and RAM control signals
//                driven or consumed by the multi-cycle instruction sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface cpu_sequencer_if;
  logic       run;
  logic [7:0] rom_address;
  logic [7:0] rom_data;
  logic [7:0] opcode1;
  logic [7:0] opcode2;
  logic       carry_in;
  logic       zero_in;
  logic       carry_f;
  logic       zero_f;
  logic       alu_op;
  logic [2:0] alu_func;
  logic [2:0] reg_raddr1;
  logic [2:0] reg_raddr2;
  logic [2:0] reg_waddr;
  logic       reg_write;
  logic [1:0] mem_to_reg;
  logic       n_cs;
  logic       n_oe;
  logic       n_we;
  logic       halted;

  // Sequencer side
  modport master (
    input  run, rom_data, carry_in, zero_in,
    output rom_address, opcode1, opcode2, carry_f, zero_f,
           alu_op, alu_func, reg_raddr1, reg_raddr2, reg_waddr,
           reg_write, mem_to_reg, n_cs, n_oe, n_we, halted
  );

  // Datapath / environment side
  modport slave (
    output run, rom_data, carry_in, zero_in,
    input  rom_address, opcode1, opcode2, carry_f, zero_f,
           alu_op, alu_func, reg_raddr1, reg_raddr2, reg_waddr,
           reg_write, mem_to_reg, n_cs, n_oe, n_we, halted
  );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_sequencer
//  Description : Multi-cycle fetch/execute/writeback sequencer for the 8-bit
//                CPU; owns the PC, instruction latches and Carry/Zero flags.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  wire logic        clk,
  input  wire logic        reset,
  cpu_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    ST_FETCH1    = 3'd0,
    ST_FETCH2    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALTED    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] op1_q, op1_d;
  logic [7:0] op2_q, op2_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;

  logic dec_ldi, dec_ld, dec_st, dec_jmp, dec_halt, dec_alu;
  logic jmp_taken;
  logic in_exec_wb;

  // Instruction class decode from the latched opcode only
  assign dec_alu  = op1_q[7];
  assign dec_ldi  = (op1_q[7:4] == 4'b0001);
  assign dec_ld   = (op1_q[7:4] == 4'b0010);
  assign dec_st   = (op1_q[7:4] == 4'b0011);
  assign dec_jmp  = (op1_q[7:4] == 4'b0100);
  assign dec_halt = (op1_q[7:4] == 4'b0101);

  // Conditions test the architectural flags, never the live ALU outputs
  always_comb begin
    jmp_taken = 1'b0;
    case (op1_q[2:0])
      3'b000:  jmp_taken = 1'b1;
      3'b001:  jmp_taken = carry_q;
      3'b101:  jmp_taken = ~carry_q;
      3'b010:  jmp_taken = zero_q;
      3'b110:  jmp_taken = ~zero_q;
      default: jmp_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH1;
      pc_q    <= RESET_PC;
      op1_q   <= 8'h00;
      op2_q   <= 8'h00;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      ST_FETCH1: begin
        if (bus.run) begin
          op1_d   = bus.rom_data;
          state_d = ST_FETCH2;
        end
      end
      ST_FETCH2: begin
        op2_d   = bus.rom_data;
        pc_d    = pc_q + 8'd2;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (dec_ldi || dec_ld || dec_alu) begin
          state_d = ST_WRITEBACK;
        end else if (dec_halt) begin
          state_d = ST_HALTED;
        end else begin
          if (dec_jmp && jmp_taken) begin
            pc_d = op2_q;
          end
          state_d = ST_FETCH1;
        end
      end
      ST_WRITEBACK: begin
        if (dec_alu) begin
          carry_d = bus.carry_in;
          zero_d  = bus.zero_in;
        end
        state_d = ST_FETCH1;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH1;
    endcase
  end

  // Strobes depend on registered state/opcode only, so an async reset of
  // state_q drops them immediately without a clock edge.
  assign in_exec_wb = (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);

  always_comb begin
    bus.n_cs       = 1'b1;
    bus.n_oe       = 1'b1;
    bus.n_we       = 1'b1;
    bus.alu_op     = 1'b0;
    bus.mem_to_reg = 2'b11;
    bus.reg_write  = (state_q == ST_WRITEBACK);
    if (in_exec_wb) begin
      if (dec_ldi) begin
        bus.mem_to_reg = 2'b00;
      end
      if (dec_ld) begin
        bus.n_cs       = 1'b0;
        bus.n_oe       = 1'b0;
        bus.mem_to_reg = 2'b01;
      end
      if (dec_alu) begin
        bus.alu_op     = 1'b1;
        bus.mem_to_reg = 2'b10;
      end
    end
    if ((state_q == ST_EXECUTE) && dec_st) begin
      bus.n_cs = 1'b0;
      bus.n_we = 1'b0;
    end
  end

  assign bus.rom_address = (state_q == ST_FETCH2) ? (pc_q + 8'd1) : pc_q;
  assign bus.opcode1     = op1_q;
  assign bus.opcode2     = op2_q;
  assign bus.carry_f     = carry_q;
  assign bus.zero_f      = zero_q;
  assign bus.alu_func    = op1_q[6:4];
  assign bus.reg_raddr1  = op1_q[2:0];
  assign bus.reg_raddr2  = op2_q[2:0];
  assign bus.reg_waddr   = op1_q[2:0];
  assign bus.halted      = (state_q == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_sequencer
//  Description : Directed self-checking bench for cpu_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_sequencer_if bus();

  cpu_sequencer #(.RESET_PC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] rom [0:255];
  assign bus.rom_data = rom[bus.rom_address];

  // {n_cs, n_oe, n_we, reg_write, alu_op}; idle pattern is 5'b11100
  logic [4:0] strobes;
  assign strobes = {bus.n_cs, bus.n_oe, bus.n_we, bus.reg_write, bus.alu_op};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    bus.run      = 1'b1;
    bus.carry_in = 1'b0;
    bus.zero_in  = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h13; rom[8'h01] = 8'h5A;  // LDI r3,0x5A
    rom[8'h02] = 8'h31; rom[8'h03] = 8'h40;  // ST r1,0x40
    rom[8'h04] = 8'h22; rom[8'h05] = 8'h40;  // LD r2,0x40
    rom[8'h06] = 8'h91; rom[8'h07] = 8'h02;  // ALU func1 r1,r2
    rom[8'h08] = 8'h42; rom[8'h09] = 8'h80;  // JMP Z 0x80
    rom[8'h80] = 8'h46; rom[8'h81] = 8'h10;  // JMP NZ 0x10
    rom[8'h82] = 8'h80; rom[8'h83] = 8'h01;  // ALU func0 r0,r1
    rom[8'h84] = 8'h15; rom[8'h85] = 8'h77;  // LDI r5,0x77
    rom[8'h86] = 8'h41; rom[8'h87] = 8'hFF;  // JMP C 0xFF
    rom[8'hFF] = 8'h00;                      // NOP (opcode2 wraps to ROM[0])

    repeat (2) @(negedge clk);
    check_value("rst_strobes", strobes, 5'b11100);
    check_value("rst_m2r", bus.mem_to_reg, 2'b11);
    check_value("rst_halted", bus.halted, 1'b0);
    check_value("rst_op", {bus.opcode1, bus.opcode2}, 16'h0000);
    check_value("rst_flags", {bus.carry_f, bus.zero_f}, 2'b00);
    reset = 1'b1;

    // LDI r3,0x5A
    check_value("ldi_f1_addr", bus.rom_address, 8'h00);
    tick();
    check_value("ldi_f2_addr", bus.rom_address, 8'h01);
    check_value("ldi_op1", bus.opcode1, 8'h13);
    check_value("ldi_f2_wr", bus.reg_write, 1'b0);
    tick();
    check_value("ldi_op2", bus.opcode2, 8'h5A);
    check_value("ldi_ex_wr", bus.reg_write, 1'b0);
    tick();
    check_value("ldi_wb_wr", bus.reg_write, 1'b1);
    check_value("ldi_wb_waddr", bus.reg_waddr, 3'd3);
    check_value("ldi_wb_m2r", bus.mem_to_reg, 2'b00);
    tick();
    check_value("ldi_next_wr", bus.reg_write, 1'b0);
    check_value("ldi_next_addr", bus.rom_address, 8'h02);

    // ST r1,0x40
    ticks(2);
    check_value("st_ex_ram", {bus.n_cs, bus.n_we, bus.n_oe}, 3'b001);
    check_value("st_raddr1", bus.reg_raddr1, 3'd1);
    check_value("st_ex_wr", bus.reg_write, 1'b0);
    tick();
    check_value("st_done_strobes", strobes, 5'b11100);
    check_value("st_next_addr", bus.rom_address, 8'h04);

    // LD r2,0x40
    ticks(2);
    check_value("ld_ex_ram", {bus.n_cs, bus.n_oe, bus.n_we}, 3'b001);
    check_value("ld_ex_m2r", bus.mem_to_reg, 2'b01);
    check_value("ld_ex_wr", bus.reg_write, 1'b0);
    tick();
    check_value("ld_wb_ram", {bus.n_cs, bus.n_oe, bus.n_we}, 3'b001);
    check_value("ld_wb_wr", bus.reg_write, 1'b1);
    check_value("ld_wb_waddr", bus.reg_waddr, 3'd2);
    tick();
    check_value("ld_done_ram", {bus.n_cs, bus.n_oe, bus.n_we}, 3'b111);
    check_value("ld_next_addr", bus.rom_address, 8'h06);

    // ALU producing zero
    bus.zero_in  = 1'b1;
    bus.carry_in = 1'b0;
    ticks(2);
    check_value("alu_ex_op", bus.alu_op, 1'b1);
    check_value("alu_func", bus.alu_func, 3'd1);
    check_value("alu_ex_m2r", bus.mem_to_reg, 2'b10);
    check_value("alu_raddr2", bus.reg_raddr2, 3'd2);
    check_value("alu_ex_wr", bus.reg_write, 1'b0);
    check_value("alu_ex_zf", bus.zero_f, 1'b0);
    tick();
    check_value("alu_wb", {bus.alu_op, bus.reg_write}, 2'b11);
    tick();
    check_value("alu_flags", {bus.carry_f, bus.zero_f}, 2'b01);
    check_value("alu_done_op", bus.alu_op, 1'b0);
    bus.zero_in = 1'b0;

    // JMP Z (taken), JMP NZ (not taken)
    ticks(3);
    check_value("jz_target", bus.rom_address, 8'h80);
    check_value("jz_zf_hold", bus.zero_f, 1'b1);
    ticks(3);
    check_value("jnz_fall", bus.rom_address, 8'h82);

    // Carry flag held across LDI, then JMP C taken
    bus.carry_in = 1'b1;
    ticks(4);
    check_value("add_flags", {bus.carry_f, bus.zero_f}, 2'b10);
    check_value("add_next_addr", bus.rom_address, 8'h84);
    bus.carry_in = 1'b0;
    ticks(4);
    check_value("ldi_cf_hold", bus.carry_f, 1'b1);
    ticks(3);
    check_value("jc_target", bus.rom_address, 8'hFF);

    // Stall at PC=FF, then wrap
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_value("stall_addr", bus.rom_address, 8'hFF);
      check_value("stall_strobes", strobes, 5'b11100);
    end
    bus.run = 1'b1;
    tick();
    check_value("wrap_f2_addr", bus.rom_address, 8'h00);
    check_value("wrap_op1", bus.opcode1, 8'h00);
    bus.run = 1'b0;
    tick();
    check_value("wrap_op2", bus.opcode2, 8'h13);
    check_value("wrap_pc", bus.rom_address, 8'h01);
    tick();
    check_value("wrap_f1_addr", bus.rom_address, 8'h01);
    tick();
    check_value("wrap_stall_addr", bus.rom_address, 8'h01);
    bus.run = 1'b1;

    // Async reset, then reset during LD WRITEBACK
    reset = 1'b0;
    #1;
    check_value("rst2_addr", bus.rom_address, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    ticks(4 + 3 + 3);
    check_value("ldwb_pre_wr", bus.reg_write, 1'b1);
    check_value("ldwb_pre_oe", bus.n_oe, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_value("ldwb_rst_strobes", strobes, 5'b11100);
    check_value("ldwb_rst_m2r", bus.mem_to_reg, 2'b11);
    check_value("ldwb_rst_addr", bus.rom_address, 8'h00);
    check_value("ldwb_rst_op1", bus.opcode1, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Reset during ST EXECUTE
    ticks(4 + 2);
    check_value("stex_pre_we", bus.n_we, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_value("stex_rst_strobes", strobes, 5'b11100);
    rom[8'h00] = 8'h50;
    rom[8'h01] = 8'h00;
    @(negedge clk);
    reset = 1'b1;

    // HALT
    ticks(2);
    check_value("halt_ex", bus.halted, 1'b0);
    tick();
    check_value("halt_set", bus.halted, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus.run = i[0];
      tick();
      check_value("halt_hold", bus.halted, 1'b1);
      check_value("halt_strobes", strobes, 5'b11100);
      check_value("halt_addr", bus.rom_address, 8'h02);
    end
    reset = 1'b0;
    #1;
    check_value("halt_rst", bus.halted, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 8-bit CPU. It owns the program counter and fetches the two-byte instruction (opcode1, opcode2) from the combinational ROM. It decodes the instruction and steps the register file, ALU and RAM256x8 through execute/writeback with properly timed strobes. It replaces the single-cycle combinational controller/PC pair and holds the Carry/Zero flags between instructions.

## Interface
Parameters:
- RESET_PC, 8'h00, program counter value after reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  when 0, sequencer stalls in FETCH1 (no PC advance, no strobes).
- rom_address  out  8  ROM address; PC in FETCH1, PC+1 (mod 256) in FETCH2.
- rom_data  in  8  combinational ROM read data.
- opcode1, opcode2  out  8 each  latched instruction bytes.
- carry_in, zero_in  in  1 each  ALU flag outputs.
- carry_f, zero_f  out  1 each  latched architectural flags.
- alu_op  out  1  ALU enable.
- alu_func  out  3  ALU function, = opcode1[6:4].
- reg_raddr1  out  3  = opcode1[2:0].
- reg_raddr2  out  3  = opcode2[2:0].
- reg_waddr  out  3  = opcode1[2:0].
- reg_write  out  1  one-cycle register write strobe.
- mem_to_reg  out  2  writeback select: 00 immediate (opcode2), 01 RAM data, 10 ALU out, 11 zero.
- n_cs, n_oe, n_we  out  1 each  RAM strobes, active-low; RAM address is opcode2.
- halted  out  1  high in HALTED state.

## Operation
- Decode on opcode1[7:4]: 0000 NOP; 0001 LDI rd<=opcode2; 0010 LD rd<=RAM[opcode2]; 0011 ST RAM[opcode2]<=rd; 0100 JMP; 0101 HALT; 1xxx ALU rd<=rd op rs2 (func opcode1[6:4]); 0110/0111 execute as NOP.
- JMP condition opcode1[2:0]: 000 always; 001 C; 101 !C; 010 Z; 110 !Z; others never taken. Uses latched carry_f/zero_f, not live ALU flags.
- States: FETCH1 -> FETCH2 -> EXECUTE -> (WRITEBACK | FETCH1); HALTED absorbing.
- FETCH1: if run, latch opcode1<=rom_data, go FETCH2; else stay.
- FETCH2: latch opcode2<=rom_data; PC<=PC+2 (mod 256); go EXECUTE.
- EXECUTE: LDI/LD/ALU -> WRITEBACK. ST: n_cs=0, n_we=0, n_oe=1 this cycle, go FETCH1. JMP taken: PC<=opcode2; go FETCH1. NOP: go FETCH1. HALT: go HALTED.
- LD in EXECUTE and WRITEBACK: n_cs=0, n_oe=0, n_we=1; mem_to_reg=01.
- ALU in EXECUTE and WRITEBACK: alu_op=1, mem_to_reg=10. At end of WRITEBACK, carry_f<=carry_in, zero_f<=zero_in.
- WRITEBACK: reg_write=1 for exactly this cycle; go FETCH1.
- Flags are changed only by ALU instructions.
- Outside the cases above: n_cs=n_oe=n_we=1, alu_op=0, reg_write=0, mem_to_reg=11.
- n_oe=0 and n_we=0 never assert together.

## Timing
- Instruction cycle counts: NOP/JMP/ST/HALT 3, LDI/LD/ALU 4.
- Strobes are decoded from registered state and opcode only; no combinational path from rom_data or carry_in/zero_in to any strobe.
- PC increment wraps: PC=8'hFE -> 8'h00. Fetch at PC=8'hFF reads opcode2 from 8'h00, and PC becomes 8'h01.
- Taken JMP overrides the FETCH2 increment; the next FETCH1 reads opcode2 target.
- run is sampled only in FETCH1. Deasserting run mid-instruction lets the instruction complete.
- Reset values: state FETCH1, PC=RESET_PC, opcode1=opcode2=0, carry_f=zero_f=0, halted=0, reg_write=0, alu_op=0, n_cs=n_oe=n_we=1, mem_to_reg=11.
- Reset asserted mid-instruction deasserts all strobes immediately, without waiting for clk. No partial register write or RAM write completes after reset falls.
- HALTED exits only via reset.

## Test plan
- Reset and fetch: release reset with run=1 and ROM[0..1]=8'h13,8'h5A (LDI r3,0x5A). Required: rom_address 00,01; reg_write high only in cycle 4 with reg_waddr=3, mem_to_reg=00, opcode2=5A; then rom_address=02.
- LD/ST: ROM has ST r1,0x40 then LD r2,0x40. Required: ST EXECUTE cycle has n_cs=0,n_we=0,n_oe=1. LD has n_cs=0,n_oe=0 for 2 cycles with reg_write in the second and reg_waddr=2.
- Conditional jumps: run ALU SUB giving zero_in=1, then JMP Z to 0x80 (8'h42,8'h80) and JMP NZ (8'h46). Required: first jump sets rom_address=80; the second falls through to PC+2.
- Flag hold: ALU with carry_in=1, then LDI, then JMP C. Required: carry_f stays 1 across the LDI and the jump is taken.
- Wrap and stall: start PC=8'hFF with run toggled low in FETCH1. Required: no PC change while run=0; then fetch FF,00 and PC becomes 01.
- Async reset in LD WRITEBACK and in ST EXECUTE: required strobes inactive before the next clk edge. HALT (8'h50) then holds halted=1 with no strobes for 20 cycles until reset.
